maze_path_stack: RTL
====================

// Module: maze_path_stack
// PURPOSE
//  LIFO store for the maze solver's move history. The 2-bit direction counter produces a move; this block
//  records it on advance and hands back the inverse move on backtrack (pop). After the goal is reached it
//  replays the stored path bottom-to-top over a valid/ready stream to the path-output consumer.
// PARAMETERS
//  DEPTH   256   max stored moves (power of 2)
//  PTR_W   8     pointer/count width, = log2(DEPTH)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, asynchronous, active-high
//  init          in   1      synchronous clear (same effect as rst)
//  push          in   1      record dir_in (IDLE only)
//  pop           in   1      discard top entry (IDLE only)
//  dir_in        in   2      move to record: 0 up, 1 right, 2 down, 3 left
//  top_dir       out  2      top entry; 0 when empty
//  back_dir      out  2      inverse of top entry (top_dir ^ 2'b10); 0 when empty
//  count         out  PTR_W+1  entries held
//  empty, full   out  1      count==0 / count==DEPTH
//  err_ovf       out  1      sticky: push while full
//  err_unf       out  1      sticky: pop while empty
//  replay_start  in   1      begin replay (IDLE only)
//  replay_valid  out  1      replay_dir valid
//  replay_ready  in   1      consumer accepts
//  replay_dir    out  2      replayed move, oldest first
//  replay_done   out  1      one-cycle pulse after last beat accepted
//  busy          out  1      high in REPLAY/DONE
// BEHAVIOUR
//  - rst/init: ptr=0, count=0, err_ovf=err_unf=0, replay_valid=0, replay_dir=0, replay_done=0, state IDLE.
//    Memory contents not cleared. init mid-replay aborts replay; next cycle IDLE, empty.
//  - FSM: IDLE -(replay_start & !empty)-> REPLAY -(last beat accepted)-> DONE -> IDLE.
//    replay_start while empty: stay IDLE, pulse replay_done next cycle, no beats.
//  - IDLE ops per cycle (rst/init have priority over all):
//    push only, !full: mem[ptr]<=dir_in, ptr++ ; full: ignored, err_ovf<=1.
//    pop only, !empty: ptr-- ; empty: ignored, err_unf<=1.
//    push&pop, !empty: mem[ptr-1]<=dir_in, count unchanged (replace top).
//    push&pop, empty: treated as push only, no error.
//    replay_start together with push/pop: replay_start wins, push/pop dropped.
//  - top_dir/back_dir/empty/full/count combinational from ptr; reflect update the cycle after the op edge.
//  - REPLAY: rd index starts at 0; replay_valid rises the cycle after replay_start, replay_dir=mem[0].
//    On valid&ready at edge: rd++; if rd was count-1 drop valid, go DONE; else present mem[rd+1] next cycle
//    (back-to-back beats at ready=1, one beat/cycle). valid never drops and replay_dir never changes
//    while ready=0. push/pop ignored in REPLAY/DONE with no error flags.
//  - DONE: replay_done=1 for exactly one cycle; stack contents and count preserved (path replayable again).
//  - Widths: count is PTR_W+1 so DEPTH is representable; ptr arithmetic never wraps (guarded by full/empty).
// STRUCTURE
//  - Shared package maze_pkg: dir_t (2-bit enum UP/RIGHT/DOWN/LEFT), function dir_inverse(d)=d^2'b10,
//    replay state enum {RS_IDLE, RS_REPLAY, RS_DONE}.
//  - One sub-module: path_stack_mem (DEPTH x 2 RAM, one sync write port, one async read for top,
//    one async read for replay index). FSM, pointers, flags in this top module.
// TESTING
//  1. rst mid-run then push 1,2,3 -> count=3, top_dir=3, back_dir=1; pop -> top_dir=2, back_dir=0.
//  2. pop on empty -> count stays 0, err_unf=1 until init; push+pop on empty with dir_in=2 -> count=1, top=2.
//  3. fill DEPTH pushes -> full=1, count=256; extra push -> count 256, err_ovf=1; push&pop with dir 0 -> top=0.
//  4. push 0,1,2,3, replay with ready=1 -> beats 0,1,2,3 on 4 consecutive cycles, replay_done next, count=4.
//  5. replay with ready toggled 1,0,0,1,... -> replay_dir stable while ready=0, exactly 4 beats, no loss/dup.
//  6. init asserted after 2nd beat -> next cycle busy=0, replay_valid=0, count=0; replay_start while empty
//     -> replay_done pulse, zero beats.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types for the maze solver: move directions, their inverse, and the path replay states.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_REPLAY,
        RS_DONE
    } rs_state_e;

    // Opposite direction is the same axis with the sign bit flipped.
    function automatic dir_t dir_inverse(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/maze_path_stack_if.sv
// Control, status and replay-stream bundle between the maze solver and its path stack.
interface maze_path_stack_if #(
    parameter int unsigned PTR_W = 8
);
    logic             init;
    logic             push;
    logic             pop;
    logic [1:0]       dir_in;
    logic [1:0]       top_dir;
    logic [1:0]       back_dir;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             err_ovf;
    logic             err_unf;
    logic             replay_start;
    logic             replay_valid;
    logic             replay_ready;
    logic [1:0]       replay_dir;
    logic             replay_done;
    logic             busy;

    modport master (
        output init, push, pop, dir_in, replay_start, replay_ready,
        input  top_dir, back_dir, count, empty, full, err_ovf, err_unf,
               replay_valid, replay_dir, replay_done, busy
    );

    modport slave (
        input  init, push, pop, dir_in, replay_start, replay_ready,
        output top_dir, back_dir, count, empty, full, err_ovf, err_unf,
               replay_valid, replay_dir, replay_done, busy
    );

endinterface

// File: rtl/path_stack_mem.sv
// Move-history RAM: one synchronous write port, async reads for the stack top and replay index.
module path_stack_mem
    import maze_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  dir_t          wdata_i,
    input  logic [AW-1:0] top_addr_i,
    output dir_t          top_data_o,
    input  logic [AW-1:0] rep_addr_i,
    output dir_t          rep_data_o
);

    dir_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign top_data_o = mem[top_addr_i];
    assign rep_data_o = mem[rep_addr_i];

endmodule

// File: rtl/maze_path_stack.sv
// LIFO of solver moves with backtrack support and an oldest-first valid/ready replay of the path.
module maze_path_stack
    import maze_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned PTR_W = 8
) (
    input logic              clk,
    input logic              rst,
    maze_path_stack_if.slave bus
);

    localparam int unsigned CW = PTR_W + 1;

    rs_state_e        state_q, state_d;
    logic [PTR_W:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    dir_t             rdir_q, rdir_d;

    logic             empty, full;
    logic             wr_en;
    logic [PTR_W-1:0] wr_addr, top_addr, rep_addr;
    dir_t             wr_data, top_rd, rep_rd;

    assign empty    = (ptr_q == '0);
    assign full     = (ptr_q == CW'(DEPTH));
    assign top_addr = PTR_W'(ptr_q - CW'(1));
    // Prefetch the beat after the current one so the next replay_dir is ready at the accept edge.
    assign rep_addr = (state_q == RS_REPLAY) ? rd_q + PTR_W'(1) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        rdir_d  = rdir_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q[PTR_W-1:0];
        wr_data = dir_t'(bus.dir_in);

        if (bus.init) begin
            state_d = RS_IDLE;
            ptr_d   = '0;
            rd_d    = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            valid_d = 1'b0;
            rdir_d  = UP;
        end else begin
            unique case (state_q)
                RS_IDLE: begin
                    if (bus.replay_start) begin
                        if (empty) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = RS_REPLAY;
                            rd_d    = '0;
                            valid_d = 1'b1;
                            rdir_d  = rep_rd;
                        end
                    end else if (bus.push && bus.pop) begin
                        wr_en = 1'b1;
                        if (empty) begin
                            ptr_d = ptr_q + CW'(1);
                        end else begin
                            wr_addr = top_addr;
                        end
                    end else if (bus.push) begin
                        if (full) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            ptr_d = ptr_q + CW'(1);
                        end
                    end else if (bus.pop) begin
                        if (empty) begin
                            unf_d = 1'b1;
                        end else begin
                            ptr_d = ptr_q - CW'(1);
                        end
                    end
                end
                RS_REPLAY: begin
                    if (valid_q && bus.replay_ready) begin
                        if (rd_q == top_addr) begin
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                            state_d = RS_DONE;
                        end else begin
                            rd_d   = rd_q + PTR_W'(1);
                            rdir_d = rep_rd;
                        end
                    end
                end
                RS_DONE: state_d = RS_IDLE;
                default: state_d = RS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RS_IDLE;
            ptr_q   <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            rdir_q  <= UP;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            rdir_q  <= rdir_d;
        end
    end

    path_stack_mem #(
        .DEPTH(DEPTH),
        .AW   (PTR_W)
    ) u_mem (
        .clk       (clk),
        .we_i      (wr_en),
        .waddr_i   (wr_addr),
        .wdata_i   (wr_data),
        .top_addr_i(top_addr),
        .top_data_o(top_rd),
        .rep_addr_i(rep_addr),
        .rep_data_o(rep_rd)
    );

    assign bus.top_dir      = empty ? 2'b00 : top_rd;
    assign bus.back_dir     = empty ? 2'b00 : dir_inverse(top_rd);
    assign bus.count        = ptr_q;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.err_ovf      = ovf_q;
    assign bus.err_unf      = unf_q;
    assign bus.replay_valid = valid_q;
    assign bus.replay_dir   = rdir_q;
    assign bus.replay_done  = done_q;
    assign bus.busy         = (state_q != RS_IDLE);

endmodule
